// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package rst_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    REL  = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Counter must hold both the largest release delay and HOLD_CYC-1.
  function automatic int cnt_width(input int cnt_w, input int hold_cyc);
    int hw;
    hw = clog2(hold_cyc);
    if (hw < 1) hw = 1;
    return (cnt_w > hw) ? cnt_w : hw;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds targeted domains in reset, then releases them one by
// one in ascending index order after a per-domain delay.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_rst_req,
  input  logic [N_DOM-1:0]       dom_mask,
  input  logic [N_DOM*CNT_W-1:0] dly,
  output logic [N_DOM-1:0]       dom_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   req_drop
);

  localparam int CW = cnt_width(CNT_W, HOLD_CYC);
  localparam int SW = (N_DOM > 1) ? clog2(N_DOM) : 1;
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_DOM - 1);

  state_t                   r_state, w_state_next;
  logic [CW-1:0]            r_cnt, w_cnt_next;
  logic [SW-1:0]            r_stage, w_stage_next;
  logic [N_DOM-1:0]         r_active_mask, w_active_mask_next;
  logic [N_DOM*CNT_W-1:0]   r_dly_q, w_dly_q_next;
  logic [N_DOM-1:0]         r_dom_rst_n, w_dom_rst_n_next;
  logic                     r_busy, w_busy_next;
  logic                     r_done, w_done_next;
  logic                     r_req_drop, w_req_drop_next;
  logic                     w_step;
  logic [CNT_W-1:0]         w_dly_arr [N_DOM];

  generate
    for (genvar gi = 0; gi < N_DOM; gi++) begin : g_dly_unpack
      assign w_dly_arr[gi] = r_dly_q[gi*CNT_W +: CNT_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= HOLD;
      r_cnt         <= '0;
      r_stage       <= '0;
      r_active_mask <= '1;
      r_dly_q       <= dly;
      r_dom_rst_n   <= '0;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_req_drop    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_stage       <= w_stage_next;
      r_active_mask <= w_active_mask_next;
      r_dly_q       <= w_dly_q_next;
      r_dom_rst_n   <= w_dom_rst_n_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
      r_req_drop    <= w_req_drop_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_stage_next       = r_stage;
    w_active_mask_next = r_active_mask;
    w_dly_q_next       = r_dly_q;
    w_dom_rst_n_next   = r_dom_rst_n;
    w_busy_next        = r_busy;
    w_done_next        = 1'b0;
    w_req_drop_next    = 1'b0;
    w_step             = 1'b0;

    case (r_state)
      IDLE: begin
        // An empty mask is deliberately a silent no-op.
        if (sw_rst_req && (|dom_mask)) begin
          w_state_next       = HOLD;
          w_cnt_next         = '0;
          w_stage_next       = '0;
          w_active_mask_next = dom_mask;
          w_dly_q_next       = dly;
          w_dom_rst_n_next   = r_dom_rst_n & ~dom_mask;
          w_busy_next        = 1'b1;
        end
      end
      HOLD: begin
        w_req_drop_next = sw_rst_req;
        if (r_cnt == HOLD_LAST) begin
          w_state_next = REL;
          w_cnt_next   = '0;
          w_stage_next = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      REL: begin
        w_req_drop_next = sw_rst_req;
        if (!r_active_mask[r_stage]) begin
          w_step = 1'b1;
        end else if (r_cnt == CW'(w_dly_arr[r_stage])) begin
          w_step                    = 1'b1;
          w_dom_rst_n_next[r_stage] = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
        if (w_step) begin
          w_cnt_next = '0;
          if (r_stage == LAST_STAGE) begin
            w_state_next = IDLE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            w_stage_next = r_stage + SW'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign dom_rst_n = r_dom_rst_n;
  assign busy      = r_busy;
  assign done      = r_done;
  assign req_drop  = r_req_drop;

endmodule
